// File: rtl/y_bus_router.sv
// Y-bus row router: filters control words by row tag and queues matches
// in a first-word-fall-through FIFO toward the X bus.
module y_bus_router #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 9,
    parameter int DEPTH    = 4,
    parameter bit BCAST_EN = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  y_id,
    input  logic [TAG_W-1:0]  tag_y,
    input  logic              from_control_enable,
    input  logic [TAG_W-1:0]  from_control_tag_x,
    input  logic [DATA_W-1:0] from_control_value,
    output logic              to_control_ready,
    output logic              to_Xbus_enable,
    output logic [TAG_W-1:0]  to_Xbus_tag_x,
    output logic [DATA_W-1:0] to_Xbus_value,
    input  logic              from_Xbus_ready,
    output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAG_W + DATA_W;

    localparam logic [CW-1:0]    FULL   = CW'(DEPTH);
    localparam logic [CW-1:0]    C_ONE  = CW'(1);
    localparam logic [PW-1:0]    P_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] N_ONE  = CNT_W'(1);
    localparam logic [TAG_W-1:0] T_ALL  = '1;

    logic [TAG_W-1:0] y_id_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;

    logic match;
    logic bcast;
    logic accept;
    logic push;
    logic pop;
    logic drop_ev;

    // Broadcast tag only counts when the build enables it.
    always_comb begin
        bcast = BCAST_EN && (tag_y == T_ALL);
        match = (tag_y == y_id_q) || bcast;
    end

    always_comb begin
        to_control_ready = (count < FULL);
        accept  = from_control_enable && to_control_ready;
        push    = accept && match;
        drop_ev = accept && !match;
    end

    always_comb begin
        to_Xbus_enable = (count != '0);
        pop  = to_Xbus_enable && from_Xbus_ready;
        head = mem[rd_ptr];
    end

    always_comb begin
        to_Xbus_tag_x = '0;
        to_Xbus_value = '0;
        if (to_Xbus_enable) begin
            to_Xbus_tag_x = head[EW-1:DATA_W];
            to_Xbus_value = head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            y_id_q <= '0;
        end else begin
            y_id_q <= y_id;
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= {from_control_tag_x, from_control_value};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            accept_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push && (accept_cnt != '1)) begin
                accept_cnt <= accept_cnt + N_ONE;
            end
            if (drop_ev && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + N_ONE;
            end
        end
    end

    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst) count <= FULL
    );

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst) (count == FULL) |-> !push
    );

endmodule

// File: tb/tb_y_bus_router.sv
// Bench for y_bus_router: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_y_bus_router;

    localparam int DW = 32;
    localparam int TW = 9;
    localparam int DP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [TW-1:0] y_id;
    logic [TW-1:0] tag_y;
    logic          en;
    logic [TW-1:0] tag_x;
    logic [DW-1:0] value;
    logic          xr;
    logic          ready;
    logic          xen;
    logic [TW-1:0] xtag;
    logic [DW-1:0] xval;
    logic [15:0]   acc;
    logic [15:0]   drop;

    logic          b_rst;
    logic [TW-1:0] b_yid;
    logic [TW-1:0] b_tag_y;
    logic          b_en;
    logic [TW-1:0] b_tag_x;
    logic [DW-1:0] b_val;
    logic          b_xr;
    logic          b_ready;
    logic          b_xen;
    logic [TW-1:0] b_xtag;
    logic [DW-1:0] b_xval;
    logic [1:0]    b_acc;
    logic [1:0]    b_drop;

    y_bus_router #(
        .DATA_W(DW), .TAG_W(TW), .DEPTH(DP),
        .BCAST_EN(1'b1), .CNT_W(16)
    ) u0 (
        .clk(clk), .rst(rst), .y_id(y_id), .tag_y(tag_y),
        .from_control_enable(en),
        .from_control_tag_x(tag_x),
        .from_control_value(value),
        .to_control_ready(ready),
        .to_Xbus_enable(xen),
        .to_Xbus_tag_x(xtag),
        .to_Xbus_value(xval),
        .from_Xbus_ready(xr),
        .accept_cnt(acc), .drop_cnt(drop)
    );

    y_bus_router #(
        .DATA_W(DW), .TAG_W(TW), .DEPTH(2),
        .BCAST_EN(1'b0), .CNT_W(2)
    ) u1 (
        .clk(clk), .rst(b_rst), .y_id(b_yid), .tag_y(b_tag_y),
        .from_control_enable(b_en),
        .from_control_tag_x(b_tag_x),
        .from_control_value(b_val),
        .to_control_ready(b_ready),
        .to_Xbus_enable(b_xen),
        .to_Xbus_tag_x(b_xtag),
        .to_Xbus_value(b_xval),
        .from_Xbus_ready(b_xr),
        .accept_cnt(b_acc), .drop_cnt(b_drop)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queue of {tag_x, value} plus counters.
    logic [TW+DW-1:0] mq[$];
    logic [TW-1:0]    m_yid;
    int               m_acc;
    int               m_drop;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [TW+DW-1:0] h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        check("ready", 64'(ready), 64'(mq.size() < DP));
        check("xen", 64'(xen), 64'(mq.size() != 0));
        check("xtag", 64'(xtag), 64'(h[TW+DW-1:DW]));
        check("xval", 64'(xval), 64'(h[DW-1:0]));
        check("acc", 64'(acc), 64'(m_acc));
        check("drop", 64'(drop), 64'(m_drop));
    endtask

    task automatic model_update();
        bit hit;
        bit take;
        bit out;
        if (!rst) begin
            mq.delete();
            m_yid = '0;
            m_acc = 0;
            m_drop = 0;
        end else begin
            hit = (tag_y == m_yid) || (tag_y == 9'h1FF);
            take = en && (mq.size() < DP);
            out = xr && (mq.size() != 0);
            if (out) void'(mq.pop_front());
            if (take && hit) begin
                mq.push_back({tag_x, value});
                if (m_acc < 65535) m_acc++;
            end
            if (take && !hit && m_drop < 65535) m_drop++;
            m_yid = y_id;
        end
    endtask

    task automatic step(input bit chk);
        if (chk) model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          rst;
        int          y_id;
        int          tag_y;
        int          en;
        int          tag_x;
        logic [31:0] value;
        int          xr;
        int          ready;
        int          xen;
        int          xtag;
        logic [31:0] xval;
        int          acc;
        int          drop;
    } vec_t;

    vec_t tbl[13];

    task automatic b_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1, 5, 0,     0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0, 0};
        tbl[1]  = '{1, 5, 5,     1, 3, 32'hA5A5A5A5, 1, 1, 0, 0, 32'h0,        0, 0};
        tbl[2]  = '{1, 5, 0,     0, 0, 32'h0,        1, 1, 1, 3, 32'hA5A5A5A5, 1, 0};
        tbl[3]  = '{1, 5, 6,     1, 7, 32'h1234,     1, 1, 0, 0, 32'h0,        1, 0};
        tbl[4]  = '{1, 5, 0,     0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        1, 1};
        tbl[5]  = '{1, 5, 9'h1FF,1, 1, 32'hBCBC,     0, 1, 0, 0, 32'h0,        1, 1};
        tbl[6]  = '{1, 5, 0,     0, 0, 32'h0,        0, 1, 1, 1, 32'hBCBC,     2, 1};
        tbl[7]  = '{1, 5, 0,     0, 0, 32'h0,        1, 1, 1, 1, 32'hBCBC,     2, 1};
        tbl[8]  = '{1, 5, 0,     0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        2, 1};
        tbl[9]  = '{1, 9, 5,     1, 2, 32'h22,       0, 1, 0, 0, 32'h0,        2, 1};
        tbl[10] = '{1, 9, 5,     1, 4, 32'h44,       0, 1, 1, 2, 32'h22,       3, 1};
        tbl[11] = '{1, 9, 0,     0, 0, 32'h0,        1, 1, 1, 2, 32'h22,       3, 2};
        tbl[12] = '{1, 5, 0,     0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        3, 2};

        rst = 1'b0; y_id = 9'd5; tag_y = '0; en = 1'b0;
        tag_x = '0; value = '0; xr = 1'b1;
        b_rst = 1'b0; b_yid = 9'd5; b_tag_y = '0; b_en = 1'b0;
        b_tag_x = '0; b_val = '0; b_xr = 1'b1;
        m_yid = '0; m_acc = 0; m_drop = 0;
        #1;
        step(1'b0);
        step(1'b0);

        for (int i = 0; i < 13; i++) begin
            rst   = tbl[i].rst[0];
            y_id  = tbl[i].y_id[TW-1:0];
            tag_y = tbl[i].tag_y[TW-1:0];
            en    = tbl[i].en[0];
            tag_x = tbl[i].tag_x[TW-1:0];
            value = tbl[i].value;
            xr    = tbl[i].xr[0];
            check($sformatf("t%0d_ready", i), 64'(ready), 64'(tbl[i].ready));
            check($sformatf("t%0d_xen", i), 64'(xen), 64'(tbl[i].xen));
            check($sformatf("t%0d_xtag", i), 64'(xtag), 64'(tbl[i].xtag));
            check($sformatf("t%0d_xval", i), 64'(xval), 64'(tbl[i].xval));
            check($sformatf("t%0d_acc", i), 64'(acc), 64'(tbl[i].acc));
            check($sformatf("t%0d_drop", i), 64'(drop), 64'(tbl[i].drop));
            step(1'b1);
        end

        // Fill with X bus stalled: fifth offer sees ready low.
        y_id = 9'd5; xr = 1'b0; en = 1'b1; tag_y = 9'd5;
        for (int i = 0; i < 5; i++) begin
            tag_x = TW'(i + 10);
            value = 32'hF000 + 32'(i);
            if (i == 4) check("fill_ready5", 64'(ready), 64'(0));
            step(1'b1);
        end
        en = 1'b0; xr = 1'b1;
        step(1'b1);
        check("ready_after_pop", 64'(ready), 64'(1));
        for (int i = 0; i < 4; i++) step(1'b1);

        // Hold count at 3 with simultaneous push/pop.
        xr = 1'b0; en = 1'b1; tag_y = 9'd5;
        for (int i = 0; i < 3; i++) begin
            tag_x = TW'(i + 20);
            value = 32'hC000 + 32'(i);
            step(1'b1);
        end
        xr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tag_x = TW'(i + 30);
            value = 32'hD000 + 32'(i);
            step(1'b1);
        end
        en = 1'b0; xr = 1'b0;
        check("hold3_ready", 64'(ready), 64'(1));
        check("hold3_head", 64'(xtag), 64'(37));
        step(1'b1);

        // Mid-stream reset with handshakes active.
        rst = 1'b0; en = 1'b1; xr = 1'b1; tag_y = 9'd5;
        step(1'b1);
        rst = 1'b1; en = 1'b0; xr = 1'b0;
        check("rst_xen", 64'(xen), 64'(0));
        check("rst_xtag", 64'(xtag), 64'(0));
        check("rst_xval", 64'(xval), 64'(0));
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_acc", 64'(acc), 64'(0));
        check("rst_drop", 64'(drop), 64'(0));
        step(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 19) == 0)
                y_id = ($urandom_range(0, 1) != 0) ? 9'd5 : 9'd6;
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: tag_y = 9'd5;
                1: tag_y = 9'd6;
                2: tag_y = 9'h1FF;
                default: tag_y = TW'($urandom);
            endcase
            tag_x = TW'($urandom);
            value = $urandom;
            xr = ($urandom_range(0, 2) != 0);
            step(1'b1);
        end
        model_check();

        // Non-broadcast build with 2-bit saturating counters.
        en = 1'b0;
        b_step();
        b_rst = 1'b1;
        b_step();
        b_en = 1'b1; b_tag_y = 9'h1FF; b_tag_x = 9'd1; b_val = 32'h11;
        b_step();
        check("nb_bcast_drop", 64'(b_drop), 64'(1));
        check("nb_bcast_xen", 64'(b_xen), 64'(0));
        check("nb_bcast_acc", 64'(b_acc), 64'(0));
        b_tag_y = 9'd7;
        for (int i = 0; i < 3; i++) b_step();
        check("nb_drop_sat", 64'(b_drop), 64'(3));
        b_tag_y = 9'd5;
        for (int i = 0; i < 4; i++) begin
            b_tag_x = TW'(i + 40);
            b_step();
        end
        check("nb_acc_sat", 64'(b_acc), 64'(3));
        check("nb_drop_hold", 64'(b_drop), 64'(3));
        check("nb_head", 64'(b_xtag), 64'(43));
        b_rst = 1'b0;
        b_step();
        check("nb_rst_acc", 64'(b_acc), 64'(0));
        check("nb_rst_drop", 64'(b_drop), 64'(0));
        check("nb_rst_xen", 64'(b_xen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
